// File: rtl/mux4_pkg.sv
// Shared constants, state encoding and the round-robin pick function for the
// four-channel stream merger.
package mux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef enum logic {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL
  } state_t;

  // Search cyclically starting one past ptr; the first requesting channel wins.
  // The 2-bit index wraps naturally, so ptr=3 makes channel 0 the first candidate.
  function automatic logic [NUM_CH-1:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                                input logic [NUM_CH-1:0] valid);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && valid[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Four-way round-robin arbiter: combinational one-hot grant from the priority
// pointer, with the pointer moved to the winner whenever a grant is taken.
module rr_arb_4
  import mux4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_CH-1:0] valid,
  input  logic             en,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  sel
);

  logic [SEL_W-1:0] ptr;

  assign grant = rr_pick(ptr, valid);

  // Encode the one-hot grant into a channel index.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) sel = SEL_W'(k);
    end
  end

  // Winner becomes lowest priority for the next arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(NUM_CH - 1);
    end else if (en && |grant) begin
      ptr <= sel;
    end
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Four-to-one valid/ready stream merger with round-robin arbitration and a
// single registered output stage; o_sel tags each beat with its source channel.
// Optional build macro MUX4_GRANT_CNT_EN adds grant_cnt, four 16-bit saturating
// per-channel accepted-beat counters.
module mux_4to1_rr
  import mux4_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i0_data,
  input  logic [width-1:0] i1_data,
  input  logic [width-1:0] i2_data,
  input  logic [width-1:0] i3_data,
  input  logic [3:0]       i_valid,
  output logic [3:0]       i_ready,
  output logic [width-1:0] o_data,
  output logic [1:0]       o_sel,
  output logic             o_valid,
`ifdef MUX4_GRANT_CNT_EN
  output logic [63:0]      grant_cnt,
`endif
  input  logic             o_ready
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             any_vld;
  logic [3:0]       grant;
  logic [1:0]       sel_c;
  logic [width-1:0] data_c;

  // Stage can take a new beat when empty or when its current beat leaves now.
  assign load    = !o_valid || o_ready;
  assign any_vld = |i_valid;
  assign i_ready = {4{load}} & grant;
  assign o_valid = (state == S_FULL);

  rr_arb_4 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (i_valid),
    .en    (load),
    .grant (grant),
    .sel   (sel_c)
  );

  // Payload steering for the granted channel.
  always_comb begin
    data_c = i0_data;
    case (sel_c)
      2'd0:    data_c = i0_data;
      2'd1:    data_c = i1_data;
      2'd2:    data_c = i2_data;
      default: data_c = i3_data;
    endcase
  end

  // Output stage occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  // Occupancy next-state: fill on any request, empty only on drain without refill.
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (any_vld) state_nxt = S_FULL;
      S_FULL:  if (o_ready && !any_vld) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Capture the granted beat; payload and tag hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_sel  <= '0;
    end else if (load && any_vld) begin
      o_data <= data_c;
      o_sel  <= sel_c;
    end
  end

`ifdef MUX4_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  // Count accepted input beats per channel, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_ready[k] && cnt[k] != {CNT_W{1'b1}}) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Randomized scoreboard bench for mux_4to1_rr: the driver predicts each grant
// from round-robin rules and queues the expected beat; the monitor checks
// every presented output beat against the queue head.
module tb_mux_4to1_rr;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i0_data, i1_data, i2_data, i3_data;
  logic [3:0] i_valid;
  logic [3:0] i_ready;
  logic [7:0] o_data;
  logic [1:0] o_sel;
  logic       o_valid;
  logic       o_ready;
`ifdef MUX4_GRANT_CNT_EN
  logic [63:0] grant_cnt;
  int          mcnt [4];
`endif

  int    tests = 0;
  int    fails = 0;
  beat_t q[$];
  logic  mo_valid;
  int    last;
  logic [7:0] d [4];
  logic [3:0] vld;

  always #5 clk = ~clk;

  mux_4to1_rr #(.width(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i0_data (i0_data),
    .i1_data (i1_data),
    .i2_data (i2_data),
    .i3_data (i3_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_valid (o_valid),
`ifdef MUX4_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .o_ready (o_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting channel after 'from', scanning 0..3 cyclically; -1 if none.
  function automatic int pick(input int from, input logic [3:0] v);
    for (int i = 1; i <= 4; i++) begin
      if (v[(from + i) % 4]) return (from + i) % 4;
    end
    return -1;
  endfunction

  task automatic apply();
    i_valid = vld;
    i0_data = d[0]; i1_data = d[1]; i2_data = d[2]; i3_data = d[3];
  endtask

  // One clock of stimulus: predict, check i_ready, step the model, refresh inputs.
  task automatic cycle(input logic [3:0] mask, input int vpct, input int rpct);
    int g;
    beat_t b;
    g = (!mo_valid || o_ready) ? pick(last, vld) : -1;
    #1;
    check("i_ready", {60'd0, i_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    if (g >= 0) begin
      b.sel = 2'(g); b.data = d[g];
      q.push_back(b);
      last = g;
      mo_valid = 1'b1;
      vld[g] = 1'b0;
`ifdef MUX4_GRANT_CNT_EN
      if (mcnt[g] < 65535) mcnt[g]++;
`endif
    end else if (o_ready) begin
      mo_valid = 1'b0;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      if (!vld[k] && mask[k] && $urandom_range(99) < vpct) begin
        vld[k] = 1'b1;
        d[k]   = 8'($urandom);
      end
    end
    o_ready = ($urandom_range(99) < rpct);
    apply();
  endtask

  task automatic run(input int n, input logic [3:0] mask, input int vpct, input int rpct);
    for (int i = 0; i < n; i++) cycle(mask, vpct, rpct);
  endtask

  // Monitor: every presented beat must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("o_valid", {63'd0, o_valid}, {63'd0, mo_valid});
      if (o_valid) begin
        if (q.size() == 0) begin
          check("beat_expected", 64'd0, 64'd1);
        end else begin
          check("o_sel",  {62'd0, o_sel},  {62'd0, q[0].sel});
          check("o_data", {56'd0, o_data}, {56'd0, q[0].data});
          if (o_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; o_ready = 1'b0; vld = '0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    apply();
    mo_valid = 1'b0; last = 3;
`ifdef MUX4_GRANT_CNT_EN
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
    #12;
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_data",  {56'd0, o_data},  64'd0);
    check("rst_o_sel",   {62'd0, o_sel},   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness: all channels always requesting, consumer always ready.
    vld = 4'b1111; d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'h32; d[3] = 8'h43;
    o_ready = 1'b1; apply();
    run(8, 4'b1111, 100, 100);
    // Backpressure with two requesters, then release.
    vld = 4'b0011; apply();
    run(5, 4'b0011, 100, 0);
    run(4, 4'b0011, 100, 100);
    // Single source on channel 3.
    run(4, 4'b0000, 0, 100);
    vld = 4'b1000; d[3] = 8'h00; apply();
    for (int i = 1; i <= 6; i++) begin
      cycle(4'b0000, 0, 100);
      if (i < 6) begin vld[3] = 1'b1; d[3] = 8'(i); apply(); end
    end
    // Drain to empty after one beat on channel 1.
    run(3, 4'b0000, 0, 100);
    vld = 4'b0010; d[1] = 8'h77; apply();
    run(3, 4'b0000, 0, 100);
    check("drain_hold_data", {56'd0, o_data}, 64'h77);
    // Randomized traffic.
    run(400, 4'b1111, 40, 70);
    run(300, 4'b1111, 90, 30);

    // Asynchronous reset while a beat is held.
    run(4, 4'b0000, 0, 100);
    vld = 4'b0001; d[0] = 8'h5A; o_ready = 1'b0; apply();
    run(3, 4'b0000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", {63'd0, o_valid}, 64'd0);
    check("arst_o_data",  {56'd0, o_data},  64'd0);
    check("arst_o_sel",   {62'd0, o_sel},   64'd0);
    q.delete(); mo_valid = 1'b0; last = 3; vld = '0; apply();
`ifdef MUX4_GRANT_CNT_EN
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    vld = 4'b0100; d[2] = 8'hA5; o_ready = 1'b1; apply();
    cycle(4'b0000, 0, 0);
    check("post_rst_valid", {63'd0, o_valid}, 64'd1);
    check("post_rst_data",  {56'd0, o_data},  64'hA5);
    check("post_rst_sel",   {62'd0, o_sel},   64'd2);
    o_ready = 1'b1; apply();
    run(4, 4'b0000, 0, 100);
    check("queue_drained", 64'(q.size()), 64'd0);
`ifdef MUX4_GRANT_CNT_EN
    for (int k = 0; k < 4; k++) check("grant_cnt", {48'd0, grant_cnt[16*k +: 16]}, 64'(mcnt[k]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
